// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 byte constants, scan FSM states and default arrow-key codes.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam logic [7:0] PS2_BRK        = 8'hF0;
   localparam logic [7:0] PS2_PAUSE      = 8'hE1;
   localparam logic [7:0] PS2_BAT        = 8'hAA;
   localparam logic [7:0] PS2_ACK        = 8'hFA;
   localparam logic [7:0] PS2_RESEND     = 8'hFE;
   localparam logic [7:0] PS2_ECHO       = 8'hEE;
   localparam logic [7:0] PS2_ERR0       = 8'h00;
   localparam logic [7:0] PS2_ERR1       = 8'hFF;
   localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;

   // Bytes following E1 that belong to the Pause make sequence
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_SKIP
   } scan_state_t;

   // {ext, code} for the arrow keys
   localparam logic [8:0] KEY_UP    = 9'h175;
   localparam logic [8:0] KEY_DOWN  = 9'h172;
   localparam logic [8:0] KEY_LEFT  = 9'h16B;
   localparam logic [8:0] KEY_RIGHT = 9'h174;

endpackage

// File: rtl/ps2_scan_fsm.sv
// Prefix decoder for the PS/2 byte stream: folds E0/F0/E1 prefixes into
// complete make/break codes, with a prefix timeout and Pause-sequence skipping.
module ps2_scan_fsm
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       code_valid,
   output logic [8:0] code,
   output logic       is_break,
   output logic       flush
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

   scan_state_t   state, state_eff, state_next;
   logic [TW-1:0] tmo_cnt, tmo_next;
   logic [2:0]    skip_cnt, skip_next;
   logic          code_valid_next, is_break_next, flush_next;
   logic [8:0]    code_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         tmo_cnt    <= '0;
         skip_cnt   <= '0;
         code_valid <= 1'b0;
         code       <= '0;
         is_break   <= 1'b0;
         flush      <= 1'b0;
      end else begin
         state      <= state_next;
         tmo_cnt    <= tmo_next;
         skip_cnt   <= skip_next;
         code_valid <= code_valid_next;
         code       <= code_next;
         is_break   <= is_break_next;
         flush      <= flush_next;
      end
   end

   // A timed-out prefix is dropped and a byte arriving in that same cycle is
   // decoded as if the FSM were already idle.
   always_comb begin
      state_eff       = (state != ST_IDLE && tmo_cnt == TMO_MAX) ? ST_IDLE : state;
      state_next      = state_eff;
      skip_next       = skip_cnt;
      code_valid_next = 1'b0;
      code_next       = code;
      is_break_next   = is_break;
      flush_next      = 1'b0;

      if (rx_valid) begin
         unique case (state_eff)
            ST_IDLE: begin
               case (rx_data)
                  PS2_EXT:   state_next = ST_EXT;
                  PS2_BRK:   state_next = ST_BRK;
                  PS2_PAUSE: begin
                     state_next = ST_SKIP;
                     skip_next  = PAUSE_SKIP;
                  end
                  PS2_BAT, PS2_ERR0, PS2_ERR1: flush_next = 1'b1;
                  PS2_ACK, PS2_RESEND, PS2_ECHO: ;
                  default: begin
                     code_valid_next = 1'b1;
                     code_next       = {1'b0, rx_data};
                     is_break_next   = 1'b0;
                  end
               endcase
            end
            ST_EXT: begin
               if (rx_data == PS2_BRK) begin
                  state_next = ST_EXT_BRK;
               end else if (rx_data != PS2_FAKE_SHIFT && rx_data != PS2_EXT) begin
                  state_next      = ST_IDLE;
                  code_valid_next = 1'b1;
                  code_next       = {1'b1, rx_data};
                  is_break_next   = 1'b0;
               end
            end
            ST_BRK: begin
               state_next      = ST_IDLE;
               code_valid_next = 1'b1;
               code_next       = {1'b0, rx_data};
               is_break_next   = 1'b1;
            end
            ST_EXT_BRK: begin
               state_next = ST_IDLE;
               if (rx_data != PS2_FAKE_SHIFT) begin
                  code_valid_next = 1'b1;
                  code_next       = {1'b1, rx_data};
                  is_break_next   = 1'b1;
               end
            end
            ST_SKIP: begin
               skip_next = skip_cnt - 3'd1;
               if (skip_cnt <= 3'd1) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end

      tmo_next = (rx_valid || state_next == ST_IDLE) ? '0 : tmo_cnt + 1'b1;
   end

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 set-2 key matrix: tracks held/press/release state for a programmable
// set of keys on top of the prefix decoder.
module ps2_key_matrix
   import ps2_pkg::*;
#(
   parameter int                    NUM_KEYS       = 4,
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP},
   parameter int                    TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   input  logic                clear,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                any_held,
   output logic [8:0]          last_code,
   output logic                last_break,
   output logic                code_strobe
);

   logic                fsm_valid, fsm_break, fsm_flush;
   logic [8:0]          fsm_code;
   logic [NUM_KEYS-1:0] held_next, press_next, release_next;

   ps2_scan_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_scan (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .code_valid(fsm_valid),
      .code      (fsm_code),
      .is_break  (fsm_break),
      .flush     (fsm_flush)
   );

   // Bulk clears drop held keys silently; a make in the same cycle still
   // lands on its slot and counts as a fresh press.
   always_comb begin
      held_next    = key_held;
      press_next   = '0;
      release_next = '0;
      if (clear || fsm_flush) held_next = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (fsm_valid && fsm_code == KEY_CODES[i*9 +: 9]) begin
            if (!fsm_break) begin
               held_next[i]  = 1'b1;
               press_next[i] = !key_held[i] || clear;
            end else begin
               held_next[i]    = 1'b0;
               release_next[i] = key_held[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_held    <= '0;
         key_press   <= '0;
         key_release <= '0;
         any_held    <= 1'b0;
         last_code   <= '0;
         last_break  <= 1'b0;
         code_strobe <= 1'b0;
      end else begin
         key_held    <= held_next;
         key_press   <= press_next;
         key_release <= release_next;
         any_held    <= |held_next;
         code_strobe <= fsm_valid;
         if (fsm_valid) begin
            last_code  <= fsm_code;
            last_break <= fsm_break;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix with a short prefix timeout and
// hand-computed expectations for each decoding scenario.
module tb_ps2_key_matrix;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] key_held, key_press, key_release;
   logic       any_held, last_break, code_strobe;
   logic [8:0] last_code;

   int total = 0;
   int bad = 0;
   int press_cnt [4];
   int rel_cnt [4];
   int strobe_cnt = 0;
   int base_p [4];
   int base_r [4];
   int base_s;

   ps2_key_matrix #(
      .NUM_KEYS      (4),
      .KEY_CODES     ({9'h174, 9'h16B, 9'h172, 9'h175}),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .clear      (clear),
      .key_held   (key_held),
      .key_press  (key_press),
      .key_release(key_release),
      .any_held   (any_held),
      .last_code  (last_code),
      .last_break (last_break),
      .code_strobe(code_strobe)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle
   initial begin
      for (int i = 0; i < 4; i++) begin
         press_cnt[i] = 0;
         rel_cnt[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            press_cnt[i] += int'(key_press[i]);
            rel_cnt[i] += int'(key_release[i]);
         end
         strobe_cnt += int'(code_strobe);
      end
   end

   task automatic snap();
      for (int i = 0; i < 4; i++) begin
         base_p[i] = press_cnt[i];
         base_r[i] = rel_cnt[i];
      end
      base_s = strobe_cnt;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      tick(2);
      total++; if (key_held !== 4'b0000) begin bad++; $display("[TB] FAIL reset_held got=%b want=0000", key_held); end
      total++; if ({key_press, key_release} !== 8'h00) begin bad++; $display("[TB] FAIL reset_pulses got=%b want=0", {key_press, key_release}); end
      total++; if ({any_held, last_break, code_strobe} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=000", {any_held, last_break, code_strobe}); end
      total++; if (last_code !== 9'h000) begin bad++; $display("[TB] FAIL reset_last_code got=%h want=000", last_code); end
      reset = 1'b1;
      tick(2);
   endtask

   task automatic test_ext_make_break();
      snap();
      send_byte(8'hE0); send_byte(8'h75); tick(2);
      total++; if (press_cnt[0] - base_p[0] !== 1) begin bad++; $display("[TB] FAIL up_press_count got=%0d want=1", press_cnt[0] - base_p[0]); end
      total++; if (key_held !== 4'b0001) begin bad++; $display("[TB] FAIL up_held got=%b want=0001", key_held); end
      total++; if (any_held !== 1'b1) begin bad++; $display("[TB] FAIL up_any_held got=%b want=1", any_held); end
      total++; if ({last_break, last_code} !== {1'b0, 9'h175}) begin bad++; $display("[TB] FAIL up_last_make got=%b/%h want=0/175", last_break, last_code); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); tick(2);
      total++; if (rel_cnt[0] - base_r[0] !== 1) begin bad++; $display("[TB] FAIL up_release_count got=%0d want=1", rel_cnt[0] - base_r[0]); end
      total++; if ({key_held, any_held} !== 5'b0) begin bad++; $display("[TB] FAIL up_after_break got=%b/%b want=0000/0", key_held, any_held); end
      total++; if ({last_break, last_code} !== {1'b1, 9'h175}) begin bad++; $display("[TB] FAIL up_last_break got=%b/%h want=1/175", last_break, last_code); end
   endtask

   task automatic test_latency();
      send_byte(8'hE0); send_byte(8'h74);
      total++; if (key_held[3] !== 1'b0) begin bad++; $display("[TB] FAIL latency_early got=%b want=0", key_held[3]); end
      tick(1);
      total++; if ({key_held, key_press, code_strobe} !== {4'b1000, 4'b1000, 1'b1}) begin bad++; $display("[TB] FAIL latency_edge got=%b/%b/%b want=1000/1000/1", key_held, key_press, code_strobe); end
      tick(1);
      total++; if ({key_held, key_press, code_strobe} !== {4'b1000, 4'b0000, 1'b0}) begin bad++; $display("[TB] FAIL pulse_width got=%b/%b/%b want=1000/0000/0", key_held, key_press, code_strobe); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74); tick(2);
   endtask

   task automatic test_typematic();
      snap();
      send_byte(8'hE0); send_byte(8'h6B);
      for (int r = 0; r < 5; r++) begin
         send_byte(8'hE0); send_byte(8'h6B); tick(1);
         total++; if (key_held[2] !== 1'b1) begin bad++; $display("[TB] FAIL repeat_held_%0d got=%b want=1", r, key_held[2]); end
      end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B); tick(2);
      total++; if (press_cnt[2] - base_p[2] !== 1) begin bad++; $display("[TB] FAIL repeat_press_count got=%0d want=1", press_cnt[2] - base_p[2]); end
      total++; if (rel_cnt[2] - base_r[2] !== 1) begin bad++; $display("[TB] FAIL repeat_release_count got=%0d want=1", rel_cnt[2] - base_r[2]); end
      total++; if (key_held !== 4'b0000) begin bad++; $display("[TB] FAIL repeat_final_held got=%b want=0000", key_held); end
   endtask

   task automatic test_non_extended();
      snap();
      send_byte(8'h75); send_byte(8'hF0); send_byte(8'h75); tick(2);
      total++; if (key_held !== 4'b0000) begin bad++; $display("[TB] FAIL kp8_held got=%b want=0000", key_held); end
      total++; if (press_cnt[0] - base_p[0] + rel_cnt[0] - base_r[0] !== 0) begin bad++; $display("[TB] FAIL kp8_pulses got=%0d want=0", press_cnt[0] - base_p[0] + rel_cnt[0] - base_r[0]); end
      total++; if (strobe_cnt - base_s !== 2) begin bad++; $display("[TB] FAIL kp8_strobes got=%0d want=2", strobe_cnt - base_s); end
      total++; if ({last_break, last_code} !== {1'b1, 9'h075}) begin bad++; $display("[TB] FAIL kp8_last got=%b/%h want=1/075", last_break, last_code); end
   endtask

   task automatic test_timeout();
      snap();
      send_byte(8'hE0); tick(100); send_byte(8'h74); tick(2);
      total++; if (press_cnt[3] - base_p[3] !== 0) begin bad++; $display("[TB] FAIL timeout_press got=%0d want=0", press_cnt[3] - base_p[3]); end
      total++; if ({last_break, last_code} !== {1'b0, 9'h074}) begin bad++; $display("[TB] FAIL timeout_last got=%b/%h want=0/074", last_break, last_code); end
      send_byte(8'hE0); tick(40); send_byte(8'h74); tick(2);
      total++; if (key_held !== 4'b1000) begin bad++; $display("[TB] FAIL within_timeout_held got=%b want=1000", key_held); end
      total++; if (last_code !== 9'h174) begin bad++; $display("[TB] FAIL within_timeout_last got=%h want=174", last_code); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74); tick(2);
   endtask

   task automatic test_fake_shift();
      snap();
      send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h72); tick(2);
      total++; if (key_held !== 4'b0010) begin bad++; $display("[TB] FAIL fake_shift_held got=%b want=0010", key_held); end
      total++; if (strobe_cnt - base_s !== 1) begin bad++; $display("[TB] FAIL fake_shift_strobes got=%0d want=1", strobe_cnt - base_s); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12); tick(2);
      total++; if ({key_held, 32'(strobe_cnt - base_s)} !== {4'b0010, 32'd1}) begin bad++; $display("[TB] FAIL ext_break_12 got=%b/%0d want=0010/1", key_held, strobe_cnt - base_s); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72); tick(2);
      total++; if (key_held !== 4'b0000) begin bad++; $display("[TB] FAIL fake_shift_release got=%b want=0000", key_held); end
   endtask

   task automatic test_pause();
      logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      snap();
      for (int i = 0; i < 8; i++) send_byte(seq[i]);
      tick(2);
      total++; if ({key_held, 32'(strobe_cnt - base_s)} !== {4'b0000, 32'd0}) begin bad++; $display("[TB] FAIL pause_quiet got=%b/%0d want=0000/0", key_held, strobe_cnt - base_s); end
      send_byte(8'hE0); send_byte(8'h72); tick(2);
      total++; if (press_cnt[1] - base_p[1] !== 1) begin bad++; $display("[TB] FAIL after_pause_press got=%0d want=1", press_cnt[1] - base_p[1]); end
      total++; if (key_held !== 4'b0010) begin bad++; $display("[TB] FAIL after_pause_held got=%b want=0010", key_held); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72); tick(2);
   endtask

   task automatic test_bat_and_clear();
      send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'h74); tick(2);
      total++; if (key_held !== 4'b1001) begin bad++; $display("[TB] FAIL two_held got=%b want=1001", key_held); end
      snap();
      send_byte(8'hAA); send_byte(8'hFA); tick(2);
      total++; if ({key_held, any_held} !== 5'b0) begin bad++; $display("[TB] FAIL bat_held got=%b/%b want=0000/0", key_held, any_held); end
      total++; if (rel_cnt[0] - base_r[0] + rel_cnt[3] - base_r[3] + strobe_cnt - base_s !== 0) begin bad++; $display("[TB] FAIL bat_silent got=%0d want=0", rel_cnt[0] - base_r[0] + rel_cnt[3] - base_r[3] + strobe_cnt - base_s); end
      send_byte(8'hE0); send_byte(8'h75); tick(2);
      snap();
      clear = 1'b1; tick(1); clear = 1'b0;
      total++; if (key_held !== 4'b0000) begin bad++; $display("[TB] FAIL clear_held got=%b want=0000", key_held); end
      tick(1);
      total++; if (rel_cnt[0] - base_r[0] !== 0) begin bad++; $display("[TB] FAIL clear_release got=%0d want=0", rel_cnt[0] - base_r[0]); end
      send_byte(8'hE0); send_byte(8'h75);
      clear = 1'b1; tick(1); clear = 1'b0;
      total++; if ({key_held, key_press} !== 8'b0001_0001) begin bad++; $display("[TB] FAIL clear_vs_make got=%b/%b want=0001/0001", key_held, key_press); end
      tick(1);
   endtask

   task automatic test_reset_mid();
      send_byte(8'hE0);
      reset = 1'b0;
      #1;
      total++; if ({key_held, any_held, last_code, last_break} !== 15'b0) begin bad++; $display("[TB] FAIL mid_reset got=%b/%b/%h/%b want=0", key_held, any_held, last_code, last_break); end
      tick(1);
      reset = 1'b1;
      send_byte(8'h75); tick(2);
      total++; if ({last_code, key_held} !== {9'h075, 4'b0000}) begin bad++; $display("[TB] FAIL post_reset_decode got=%h/%b want=075/0000", last_code, key_held); end
   endtask

   initial begin
      test_reset();
      test_ext_make_break();
      test_latency();
      test_typematic();
      test_non_extended();
      test_timeout();
      test_fake_shift();
      test_pause();
      test_bat_and_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_matrix.md
Name: ps2_key_matrix

Overview:
Parametrised PS/2 set-2 scancode decoder. It consumes the byte stream from the PS/2 receiver and keeps a held/pressed/released state for NUM_KEYS programmable keys. It handles E0 extended prefixes, F0 break codes, E1 (Pause) sequences, typematic-repeat suppression, prefix timeout and keyboard reset/overrun codes. It sits between the PS/2 receiver and the game control logic, and supersedes per-key FSM instances.

Parameters:
NUM_KEYS, 4, number of tracked keys (1..32)
KEY_CODES, {9'h174,9'h16B,9'h172,9'h175}, packed NUM_KEYS*9 bits; slot i = bits [9i+8:9i]; bit8 = E0-extended, bits7:0 = code. Default is index0=up, 1=down, 2=left, 3=right.
TIMEOUT_CYCLES, 2_000_000, max clk cycles between prefix byte and following byte (20 ms at 100 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_data  in  8  received byte from PS/2 receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
clear  in  1  synchronous: drop all held keys, no release pulses
key_held  out  NUM_KEYS  level, key currently down
key_press  out  NUM_KEYS  one-cycle pulse on first make
key_release  out  NUM_KEYS  one-cycle pulse on break of a held key
any_held  out  1  OR of key_held
last_code  out  9  {ext,code} of last completed make/break
last_break  out  1  last completed code was a break
code_strobe  out  1  one-cycle pulse when last_code updates (any code, matched or not)

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=IDLE, timeout counter 0, skip counter 0.
- All outputs registered. A byte accepted at edge N is reflected on outputs after edge N+1. Pulses last exactly one cycle.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
  - IDLE: E0->EXT; F0->BRK; E1->SKIP with skip_cnt=7. AA, 00 or FF: all key_held cleared, no release pulses. FA, FE, EE: ignored. Any other byte: make {0,b}.
  - EXT: F0->EXT_BRK; 12 or E0->stay in EXT (fake-shift/duplicate prefix). Other byte: make {1,b}, ->IDLE.
  - BRK: byte b: break {0,b}, ->IDLE.
  - EXT_BRK: byte 12: ->IDLE, no action. Other byte: break {1,b}, ->IDLE.
  - SKIP: each rx_valid decrements skip_cnt; at 0 ->IDLE. No key effects.
- Timeout: in EXT, BRK, EXT_BRK and SKIP, the counter increments each cycle without rx_valid and resets to 0 on rx_valid. Reaching TIMEOUT_CYCLES-1 forces IDLE; the pending prefix is discarded. Counter width is $clog2(TIMEOUT_CYCLES).
- Make {e,c}: for every i with KEY_CODES[i]=={e,c}:
  - If key_held[i]=0: set it and pulse key_press[i].
  - If already held (typematic repeat): no pulse.
- Break {e,c}: for matching i:
  - If key_held[i]=1: clear it and pulse key_release[i].
  - If not held: no pulse.
- Any make/break, matched or not, updates last_code and last_break and pulses code_strobe.
- Duplicate entries in KEY_CODES are legal; all matching slots update.
- clear=1: key_held cleared the next cycle with no pulses. FSM state is unaffected. If clear and a make arrive in the same cycle, the make wins for its slot, so held=1 and press pulses.
- rx_valid while the FSM is forced to IDLE by timeout on the same cycle: the byte is processed as IDLE input.
- Extended and non-extended codes are distinct: E0 75 (up arrow) never matches 9'h075 (keypad 8).

Decomposition:
- Package ps2_pkg: byte constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA, PS2_RESEND=FE, PS2_ECHO=EE, PS2_ERR0=00, PS2_ERR1=FF, PS2_FAKE_SHIFT=12; FSM state enum; default arrow-key code constants.
- Sub-module ps2_scan_fsm: owns the prefix FSM, timeout and E1 skip. It outputs code_valid, code[8:0] and is_break, registered with one-cycle latency.
- ps2_key_matrix instantiates ps2_scan_fsm and contains the NUM_KEYS compare/hold/pulse array. Total latency from rx_valid to outputs is 2 cycles; it is spec'd as 2.

Test Plan:
- Bytes E0 75 -> key_press[0] pulses once, key_held=4'b0001, last_code=9'h175, last_break=0. Then E0 F0 75 -> key_release[0] pulses, key_held=0, last_break=1.
- E0 6B, then E0 6B repeated 5 times, then E0 F0 6B -> exactly one key_press[2] pulse, exactly one key_release[2] pulse, key_held[2]=1 throughout the repeats.
- 75 then F0 75 (non-extended) -> key_held stays 0, no pulses, code_strobe pulses twice, last_code=9'h075.
- E0 then 2_000_000 idle cycles, then 74 -> prefix timed out; 74 treated as {0,74}: no key_press[3], last_code=9'h074.
- E1 14 77 E1 F0 14 F0 77, then E0 72 -> no effect during the Pause sequence; then key_press[1] pulses and key_held=4'b0010.
- Hold keys 0 and 3, then byte AA -> key_held=0 with no release pulses. Repeat holding key 0, drive clear=1 for one cycle -> key_held=0. Assert reset=0 mid-sequence after E0 -> all outputs 0 immediately; a following 75 decodes as {0,75}.
